fp_round_normalize: RTL and testbench

Iterative normalize/round stage of the FPDSP_Iterative single-precision multiplier. It takes the raw 48-bit DSP48E1 mantissa product, the sign and the unbiased exponent sum, and normalizes the value one shift per cycle, including the gradual-underflow right shifts. It then applies round-to-nearest-even and delivers the packed result together with the NegE/R/S/EOF/exception bundle consumed by ExceptionModule. A valid/ready handshake on both sides supports multi-cycle operation and backpressure.

---
 rtl/fpdsp_pkg.sv | 27 ++
 rtl/fp_rne_rounder.sv | 21 ++
 rtl/fp_round_normalize.sv | 220 ++++++++++++++++++++++
 tb/tb_fp_round_normalize.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fpdsp_pkg.sv
// Shared definitions for the FPDSP_Iterative multiplier datapath:
// IEEE-754 single-precision constants, exception bit positions and
// the state encoding of the iterative normalize/round stage.
package fpdsp_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_INF  = 255;
    localparam int FRAC_W   = 23;
    localparam int SIG_W    = FRAC_W + 1;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Exception bundle layout: [4:2] invalid-operation causes, [1:0] infinite operand.
    localparam int EXC_INV_MSB = 4;
    localparam int EXC_INV_LSB = 2;
    localparam int EXC_INF_MSB = 1;
    localparam int EXC_INF_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NORM,
        ST_DENORM,
        ST_ROUND,
        ST_DONE
    } state_e;

endpackage

// File: rtl/fp_rne_rounder.sv
// Round-to-nearest-even on a 24-bit significand given the round and
// sticky bits. Purely combinational; shared by multiplier and adder paths.
module fp_rne_rounder
    import fpdsp_pkg::*;
(
    input  logic [SIG_W-1:0] sig_i,
    input  logic             r_i,
    input  logic             s_i,
    output logic [SIG_W-1:0] sig_o,
    output logic             carry_o
);

    logic inc;

    // Increment when above half, or exactly half with an odd LSB (ties to even).
    always_comb begin
        inc              = r_i & (s_i | sig_i[0]);
        {carry_o, sig_o} = {1'b0, sig_i} + {{SIG_W{1'b0}}, inc};
    end

endmodule

// File: rtl/fp_round_normalize.sv
// Iterative normalize/round stage: takes the raw Q2.46 mantissa product,
// normalizes one bit per cycle (including gradual-underflow right shifts),
// rounds to nearest even and hands the packed result plus the
// NegE/R/S/EOF/exception bundle to the exception logic.
module fp_round_normalize
    import fpdsp_pkg::*;
#(
    parameter int DENORM_MAX_SHIFT = 25,
    parameter int MAX_LSHIFT       = 46
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sgn,
    input  logic [9:0]  in_exp,
    input  logic [47:0] in_mant,
    input  logic [4:0]  in_exc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] z,
    output logic        neg_e,
    output logic        r,
    output logic        s,
    output logic        eof,
    output logic [4:0]  exc_out
);

    // The shift counter reaches the "last" value on the cycle that performs the final allowed shift.
    localparam logic [5:0]        LSHIFT_LAST = 6'(MAX_LSHIFT - 1);
    localparam logic [5:0]        DENORM_LAST = 6'(DENORM_MAX_SHIFT - 1);
    localparam logic signed [11:0] EXP_INF_S  = 12'(EXP_INF);

    state_e             state_q;
    logic               sgn_q;
    logic signed [11:0] exp_q;
    logic [47:0]        mant_q;
    logic               sticky_q;
    logic [5:0]         cnt_q;
    logic [31:0]        z_q;
    logic               neg_e_q;
    logic               r_q;
    logic               s_q;
    logic               eof_q;
    logic [4:0]         exc_q;
    logic               out_valid_q;

    logic [47:0]        mant_nrm_d;
    logic signed [11:0] exp_nrm_d;
    logic               sticky_nrm_d;
    logic               norm_done;
    logic [47:0]        mant_dn_d;
    logic signed [11:0] exp_dn_d;
    logic               sticky_dn_d;
    logic               denorm_done;
    logic [31:0]        z_byp;

    logic [SIG_W-1:0]   sig_rnd;
    logic               r_rnd;
    logic               s_rnd;
    logic [SIG_W-1:0]   rsig;
    logic               rcarry;
    logic [SIG_W-1:0]   fsig;
    logic signed [11:0] exp_rnd;
    logic [31:0]        z_rnd;
    logic               eof_rnd;

    // Bypass result for exceptional operands or an exactly-zero product.
    always_comb begin
        if (in_exc[EXC_INV_MSB:EXC_INV_LSB] != '0) begin
            z_byp = QNAN;
        end else if (in_exc[EXC_INF_MSB:EXC_INF_LSB] != '0) begin
            z_byp = {in_sgn, 8'hFF, 23'b0};
        end else begin
            z_byp = {in_sgn, 31'b0};
        end
    end

    // One normalize step: pull an overflowing integer bit down, or push a leading zero out.
    always_comb begin
        mant_nrm_d   = mant_q;
        exp_nrm_d    = exp_q;
        sticky_nrm_d = sticky_q;
        if (mant_q[47]) begin
            mant_nrm_d   = {1'b0, mant_q[47:1]};
            exp_nrm_d    = exp_q + 12'sd1;
            sticky_nrm_d = sticky_q | mant_q[0];
        end else if (!mant_q[46]) begin
            mant_nrm_d = {mant_q[46:0], 1'b0};
            exp_nrm_d  = exp_q - 12'sd1;
        end
        norm_done = (mant_nrm_d[47:46] == 2'b01) || (cnt_q == LSHIFT_LAST);
    end

    // One gradual-underflow step: shift right until the exponent reaches the denormal floor.
    always_comb begin
        mant_dn_d   = {1'b0, mant_q[47:1]};
        exp_dn_d    = exp_q + 12'sd1;
        sticky_dn_d = sticky_q | mant_q[0];
        denorm_done = (exp_dn_d == 12'sd1) || (cnt_q == DENORM_LAST);
    end

    assign sig_rnd = mant_q[46:23];
    assign r_rnd   = mant_q[22];
    assign s_rnd   = (|mant_q[21:0]) | sticky_q;

    fp_rne_rounder u_rounder (
        .sig_i   (sig_rnd),
        .r_i     (r_rnd),
        .s_i     (s_rnd),
        .sig_o   (rsig),
        .carry_o (rcarry)
    );

    // Renormalize a rounding carry and pack; a denormal that rounds into bit 23 becomes the smallest normal.
    always_comb begin
        fsig    = rcarry ? {1'b1, rsig[SIG_W-1:1]} : rsig;
        exp_rnd = rcarry ? (exp_q + 12'sd1) : exp_q;
        eof_rnd = 1'b0;
        if (neg_e_q) begin
            z_rnd = {sgn_q, 7'b0, fsig[FRAC_W], fsig[FRAC_W-1:0]};
        end else if (exp_rnd >= EXP_INF_S) begin
            z_rnd   = {sgn_q, 8'hFF, 23'b0};
            eof_rnd = 1'b1;
        end else begin
            z_rnd = {sgn_q, exp_rnd[7:0], fsig[FRAC_W-1:0]};
        end
    end

    // Control FSM with registered result and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sgn_q       <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
            z_q         <= '0;
            neg_e_q     <= 1'b0;
            r_q         <= 1'b0;
            s_q         <= 1'b0;
            eof_q       <= 1'b0;
            exc_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        sgn_q    <= in_sgn;
                        exp_q    <= {{2{in_exp[9]}}, in_exp};
                        mant_q   <= in_mant;
                        exc_q    <= in_exc;
                        sticky_q <= 1'b0;
                        cnt_q    <= '0;
                        neg_e_q  <= 1'b0;
                        r_q      <= 1'b0;
                        s_q      <= 1'b0;
                        eof_q    <= 1'b0;
                        if ((in_exc != '0) || (in_mant == '0)) begin
                            z_q         <= z_byp;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            z_q     <= '0;
                            state_q <= ST_NORM;
                        end
                    end
                end
                ST_NORM: begin
                    mant_q   <= mant_nrm_d;
                    exp_q    <= exp_nrm_d;
                    sticky_q <= sticky_nrm_d;
                    cnt_q    <= cnt_q + 6'd1;
                    if (norm_done) begin
                        cnt_q   <= '0;
                        state_q <= (exp_nrm_d < 12'sd1) ? ST_DENORM : ST_ROUND;
                    end
                end
                ST_DENORM: begin
                    mant_q   <= mant_dn_d;
                    exp_q    <= exp_dn_d;
                    sticky_q <= sticky_dn_d;
                    neg_e_q  <= 1'b1;
                    cnt_q    <= cnt_q + 6'd1;
                    if (denorm_done) begin
                        state_q <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    z_q         <= z_rnd;
                    r_q         <= r_rnd;
                    s_q         <= s_rnd;
                    eof_q       <= eof_rnd;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign z         = z_q;
    assign neg_e     = neg_e_q;
    assign r         = r_q;
    assign s         = s_q;
    assign eof       = eof_q;
    assign exc_out   = exc_q;

endmodule

// File: tb/tb_fp_round_normalize.sv
// Self-checking bench for fp_round_normalize: a table of operand bundles
// with hand-derived results and latencies, driven through a scoreboard
// queue, plus backpressure and mid-operation reset sequences.
module tb_fp_round_normalize;
    import fpdsp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sgn = 1'b0;
    logic [9:0]  in_exp = '0;
    logic [47:0] in_mant = '0;
    logic [4:0]  in_exc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] z;
    logic        neg_e;
    logic        r;
    logic        s;
    logic        eof;
    logic [4:0]  exc_out;

    // flags = {neg_e, r, s, eof}
    typedef struct {
        string       name;
        logic        sgn;
        logic [9:0]  exp;
        logic [47:0] mant;
        logic [4:0]  exc;
        logic [31:0] z;
        logic [3:0]  flags;
        int          lat;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs[NVEC];
    vec_t sbQ[$];
    int   passCount = 0;
    int   checkCount = 0;

    fp_round_normalize #(
        .DENORM_MAX_SHIFT (25),
        .MAX_LSHIFT       (46)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sgn    (in_sgn),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .in_exc    (in_exc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .neg_e     (neg_e),
        .r         (r),
        .s         (s),
        .eof       (eof),
        .exc_out   (exc_out)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    function automatic vec_t mk(string n, logic sg, logic [9:0] e, logic [47:0] m, logic [4:0] x,
                                logic [31:0] ez, logic [3:0] ef, int el);
        vec_t v;
        v.name = n; v.sgn = sg; v.exp = e; v.mant = m; v.exc = x;
        v.z = ez; v.flags = ef; v.lat = el;
        return v;
    endfunction

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
        checkCount++;
        if (act === req) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Wait for a free slot, present the bundle and let it be accepted on the next rising edge.
    task automatic applyStimulus(input vec_t v);
        int waited = 0;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check({v.name, " ready"}, {47'b0, in_ready}, 48'd1);
        in_sgn  = v.sgn;
        in_exp  = v.exp;
        in_mant = v.mant;
        in_exc  = v.exc;
        in_valid = 1'b1;
        sbQ.push_back(v);
        @(posedge clk);
    endtask

    // Count cycles from the accept edge until out_valid, bounded.
    task automatic waitOutput(input string name, output int lat, output bit ok);
        lat = 0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (i == 0) begin
                in_valid = 1'b0;
                check({name, " busy"}, {47'b0, in_ready}, 48'd0);
            end
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Pop the oldest expectation and compare it with what the DUT presents now.
    task automatic checkOutput(input int lat, input bit ok);
        vec_t e;
        if (sbQ.size() == 0) begin
            check("scoreboard empty", 48'd0, 48'd1);
            return;
        end
        e = sbQ.pop_front();
        if (!ok) begin
            check({e.name, " timeout"}, 48'd0, 48'd1);
            return;
        end
        check({e.name, " z"}, {16'b0, z}, {16'b0, e.z});
        check({e.name, " flags"}, {44'b0, neg_e, r, s, eof}, {44'b0, e.flags});
        check({e.name, " exc_out"}, {43'b0, exc_out}, {43'b0, e.exc});
        check({e.name, " latency"}, 48'(lat), 48'(e.lat));
    endtask

    initial begin
        int  lat;
        bit  ok;

        vecs[0]  = mk("mul1p5",    1'b0, 10'd127, 48'h9000_0000_0000, 5'b00000, 32'h4010_0000, 4'b0000, 3);
        vecs[1]  = mk("tie_even",  1'b0, 10'd127, 48'h4000_0040_0000, 5'b00000, 32'h3F80_0000, 4'b0100, 3);
        vecs[2]  = mk("tie_odd",   1'b0, 10'd127, 48'h4000_00C0_0000, 5'b00000, 32'h3F80_0002, 4'b0100, 3);
        vecs[3]  = mk("underflow", 1'b0, 10'h3FF, 48'h4000_0000_0000, 5'b00000, 32'h0020_0000, 4'b1000, 5);
        vecs[4]  = mk("overflow",  1'b1, 10'd254, 48'h8000_0000_0000, 5'b00000, 32'hFF80_0000, 4'b0001, 3);
        vecs[5]  = mk("exc_inv",   1'b0, 10'd127, 48'h4000_0000_0000, 5'b00100, QNAN,          4'b0000, 1);
        vecs[6]  = mk("exc_inf",   1'b1, 10'd127, 48'h4000_0000_0000, 5'b00001, 32'hFF80_0000, 4'b0000, 1);
        vecs[7]  = mk("zero",      1'b1, 10'd127, 48'h0,              5'b00000, 32'h8000_0000, 4'b0000, 1);
        vecs[8]  = mk("lshift2",   1'b0, 10'd127, 48'h1000_0000_0000, 5'b00000, 32'h3E80_0000, 4'b0000, 4);
        vecs[9]  = mk("rnd_carry", 1'b0, 10'd127, 48'h7FFF_FFC0_0000, 5'b00000, 32'h4000_0000, 4'b0100, 3);
        vecs[10] = mk("dn_cap",    1'b0, 10'h3E2, 48'h4000_0000_0001, 5'b00000, 32'h0000_0000, 4'b1010, 28);
        vecs[11] = mk("dn_to_min", 1'b0, 10'd0,   48'h7FFF_FF80_0000, 5'b00000, 32'h0080_0000, 4'b1100, 4);
        vecs[12] = mk("exp_huge",  1'b0, 10'd383, 48'h4000_0000_0000, 5'b00000, 32'h7F80_0000, 4'b0001, 3);

        // Reset values while reset is held, then ready once released.
        repeat (2) @(negedge clk);
        check("rst out_valid", {47'b0, out_valid}, 48'd0);
        check("rst z", {16'b0, z}, 48'd0);
        check("rst flags", {39'b0, neg_e, r, s, eof, exc_out}, 48'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst in_ready", {47'b0, in_ready}, 48'd1);

        // Table of operand bundles, each drained immediately.
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            waitOutput(vecs[i].name, lat, ok);
            checkOutput(lat, ok);
        end

        // Backpressure: the result must hold steady while downstream stalls.
        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(vecs[0]);
        waitOutput("bp", lat, ok);
        checkOutput(lat, ok);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp hold z", {16'b0, z}, {16'b0, vecs[0].z});
            check("bp hold valid", {46'b0, out_valid, in_ready}, 48'b10);
            check("bp hold flags", {44'b0, neg_e, r, s, eof}, {44'b0, vecs[0].flags});
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp release", {46'b0, out_valid, in_ready}, 48'b01);

        // Reset in the middle of the long underflow sequence discards it.
        applyStimulus(vecs[10]);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid busy", {47'b0, in_ready}, 48'd0);
        rst_n = 1'b0;
        #1;
        check("mid rst out_valid", {47'b0, out_valid}, 48'd0);
        check("mid rst flags", {43'b0, neg_e, r, s, eof, out_valid}, 48'd0);
        sbQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid rst in_ready", {47'b0, in_ready}, 48'd1);
        check("mid rst idle", {47'b0, out_valid}, 48'd0);

        // A fresh operation completes normally after the reset.
        applyStimulus(vecs[2]);
        waitOutput("post_rst", lat, ok);
        checkOutput(lat, ok);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
